merge_pair_ctrl: RTL and testbench
==================================

// Module: merge_pair_ctrl
// PURPOSE
// - 2-to-1 merge controller for one merger-tree node. Pops records from two
//   input FIFOs (IFIFO-style, combinational head) and pushes them into one
//   output FIFO.
// - Output stream is in descending key order. Key 0 is the end-of-stream
//   terminator.
// - Generates the deq/enq strobes and registers the winning record. Also
//   counts records and completed streams.
// PARAMETERS
// - P_WIDTH   128  record width; key = record[P_WIDTH-1 -: P_KEYW]
// - P_KEYW     32  key width
// - P_CNTW     16  width of record counter
// PORTS
// - i_clk          in   1        clock
// - i_rst          in   1        reset, asynchronous, active-high
// - i_a_data       in   P_WIDTH  head of FIFO A
// - i_a_empty      in   1        FIFO A empty
// - o_a_deq        out  1        pop FIFO A (combinational)
// - i_b_data       in   P_WIDTH  head of FIFO B
// - i_b_empty      in   1        FIFO B empty
// - o_b_deq        out  1        pop FIFO B (combinational)
// - i_out_full     in   1        output FIFO full; asserts with >=2 free slots
// - o_out_data     out  P_WIDTH  registered record to output FIFO
// - o_out_enq      out  1        registered push strobe
// - o_state        out  2        current FSM state
// - o_rec_cnt      out  P_CNTW   records emitted in current stream; terminator excluded
// - o_stream_cnt   out  8        completed streams; wraps at 255->0
// BEHAVIOUR
// - Reset values:
//   - state = MERGE
//   - o_out_enq = 0, o_out_data = 0
//   - o_rec_cnt = 0, o_stream_cnt = 0
//   - deq strobes are 0 while i_rst is high
// - fire = !i_out_full. No pop and no push occurs in a cycle without fire.
// - Pop/push timing:
//   - At most one pop per FIFO per cycle.
//   - A pop on cycle N gives a new head on cycle N+1.
//   - The popped record appears on o_out_data with o_out_enq=1 on cycle N+1
//     (latency 1).
//   - o_out_enq=0 in any cycle following no-pop.
// - Empty rule: o_x_deq is never asserted while i_x_empty=1.
// - MERGE (00):
//   - Requires both FIFOs non-empty. Either FIFO empty -> no pop.
//   - keyA==0 and keyB==0 -> TERM, no pop.
//   - keyA==0 -> DRAIN_B, no pop. keyB==0 -> DRAIN_A, no pop.
//   - Otherwise pop the larger key. keyA>=keyB pops A (tie goes to A).
// - DRAIN_A (01): B holds its terminator.
//   - A empty -> stall.
//   - keyA==0 -> TERM.
//   - Otherwise pop A.
// - DRAIN_B (10): mirror of DRAIN_A.
// - TERM (11): both heads are terminators.
//   - If fire: pop A and B in the same cycle and emit one terminator record
//     (A's head).
//   - Same cycle: o_stream_cnt+1, o_rec_cnt cleared to 0, state -> MERGE.
// - Terminator handling:
//   - A terminator is never popped alone.
//   - Exactly one terminator is emitted per stream pair.
// - o_rec_cnt increments on each non-terminator push and saturates at all-ones.
// - Reset asserted mid-stream:
//   - State and counters clear immediately.
//   - Pending o_out_enq is dropped.
//   - FIFO contents are not touched. The FIFOs are reset by their owner.
// - i_out_full rising while a push is in flight: the registered push still
//   completes. The 2-slot slack absorbs it.
// STRUCTURE
// - Shared package:
//   - state encodings MERGE/DRAIN_A/DRAIN_B/TERM
//   - terminator key constant (0)
//   - key-extract macro
//   - reused by all tree nodes
// - One sub-module, merge_sel: a combinational key compare giving a_wins and
//   a_term/b_term.
// - FSM, output register and counters stay in this module.
// TESTING
// - Interleave: A=[9,5,2,0], B=[8,5,1,0], out never full
//   -> out=9,8,5(A),5(B),2,1,0; one push per cycle; o_stream_cnt=1;
//      o_rec_cnt=6 before clear.
// - Backpressure: hold i_out_full=1 for 5 cycles mid-stream
//   -> no deq, no new enq (one in-flight enq allowed); order preserved after
//      release.
// - Empty stall: B empty for 3 cycles in MERGE with A non-empty
//   -> no pops; resume when B arrives; o_b_deq never high while empty.
// - Uneven streams: A=[0], B=[7,6,3,0]
//   -> DRAIN_B, out=7,6,3,0; A's terminator popped only in TERM together
//      with B's.
// - Back-to-back streams: two stream pairs queued
//   -> TERM->MERGE with no idle cycle; o_stream_cnt=2; 255->0 wrap checked
//      with forced count.
// - Async reset asserted mid-DRAIN_A, between clock edges
//   -> outputs/counters 0 immediately; state MERGE; no deq while reset is high.

Source files
------------

// File: rtl/merge_pair_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// merge_pair_ctrl_pkg
//   Definitions shared by every merger-tree node: FSM state encodings, the
//   end-of-stream terminator key and a key-extract macro that pulls the sort
//   key out of the most significant bits of a record.
// -----------------------------------------------------------------------------

`ifndef MPC_KEY
// Sort key of a record: the top KW bits of a W-bit record.
`define MPC_KEY(rec, w, kw) rec[(w)-1 -: (kw)]
`endif

package merge_pair_ctrl_pkg;

    // Encodings are visible on o_state, so they are fixed explicitly.
    typedef enum logic [1:0] {
        ST_MERGE   = 2'b00,
        ST_DRAIN_A = 2'b01,
        ST_DRAIN_B = 2'b10,
        ST_TERM    = 2'b11
    } state_e;

    // Key value that marks the end of a stream.
    localparam int unsigned TERM_KEY = 0;

endpackage

// File: rtl/merge_pair_ctrl_sel.sv
// -----------------------------------------------------------------------------
// merge_sel
//   Combinational key compare for one merge node.
//   key_a_i / key_b_i : head keys of FIFO A and FIFO B
//   a_wins_o          : A's key is >= B's key (ties go to A)
//   a_term_o          : A's head is a terminator
//   b_term_o          : B's head is a terminator
// -----------------------------------------------------------------------------

module merge_sel
    import merge_pair_ctrl_pkg::*;
#(
    parameter int P_KEYW = 32
) (
    input  logic [P_KEYW-1:0] key_a_i,
    input  logic [P_KEYW-1:0] key_b_i,
    output logic              a_wins_o,
    output logic              a_term_o,
    output logic              b_term_o
);

    localparam logic [P_KEYW-1:0] TERM_K = P_KEYW'(TERM_KEY);

    assign a_wins_o = (key_a_i >= key_b_i);
    assign a_term_o = (key_a_i == TERM_K);
    assign b_term_o = (key_b_i == TERM_K);

endmodule

// File: rtl/merge_pair_ctrl.sv
// -----------------------------------------------------------------------------
// merge_pair_ctrl
//   2-to-1 merge controller for one merger-tree node. Pops records from two
//   show-ahead input FIFOs and pushes them, in descending key order, into one
//   output FIFO. A key of 0 terminates a stream; one terminator is emitted per
//   pair of input streams.
//
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_a_data / i_a_empty    head and empty flag of FIFO A
//   o_a_deq                 pop FIFO A (combinational)
//   i_b_data / i_b_empty    head and empty flag of FIFO B
//   o_b_deq                 pop FIFO B (combinational)
//   i_out_full              output FIFO full (asserts with >= 2 free slots)
//   o_out_data / o_out_enq  registered record and push strobe, latency 1
//   o_state                 current FSM state
//   o_rec_cnt               records emitted in the current stream (saturating)
//   o_stream_cnt            completed streams (wrapping)
// -----------------------------------------------------------------------------

module merge_pair_ctrl
    import merge_pair_ctrl_pkg::*;
#(
    parameter int P_WIDTH = 128,
    parameter int P_KEYW  = 32,
    parameter int P_CNTW  = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [P_WIDTH-1:0] i_a_data,
    input  logic               i_a_empty,
    output logic               o_a_deq,
    input  logic [P_WIDTH-1:0] i_b_data,
    input  logic               i_b_empty,
    output logic               o_b_deq,
    input  logic               i_out_full,
    output logic [P_WIDTH-1:0] o_out_data,
    output logic               o_out_enq,
    output logic [1:0]         o_state,
    output logic [P_CNTW-1:0]  o_rec_cnt,
    output logic [7:0]         o_stream_cnt
);

    state_e               state_q, state_d;
    logic [P_WIDTH-1:0]   out_data_q, out_data_d;
    logic                 out_enq_q, out_enq_d;
    logic [P_CNTW-1:0]    rec_cnt_q, rec_cnt_d;
    logic [7:0]           stream_cnt_q, stream_cnt_d;

    logic                 a_deq, b_deq;
    logic                 a_wins, a_term, b_term;
    logic                 fire;

    merge_sel #(
        .P_KEYW (P_KEYW)
    ) u_sel (
        .key_a_i  (`MPC_KEY(i_a_data, P_WIDTH, P_KEYW)),
        .key_b_i  (`MPC_KEY(i_b_data, P_WIDTH, P_KEYW)),
        .a_wins_o (a_wins),
        .a_term_o (a_term),
        .b_term_o (b_term)
    );

    // The output FIFO keeps two spare slots, so a push already registered
    // when full rises still lands safely.
    assign fire = !i_out_full;

    // Next-state and pop decisions. State changes that do not pop are allowed
    // without fire; every pop requires fire.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave it unassigned and infer a latch.
        state_d = state_q;
        a_deq   = 1'b0;
        b_deq   = 1'b0;

        case (state_q)
            ST_MERGE: begin
                if (!i_a_empty && !i_b_empty) begin
                    if (a_term && b_term)  state_d = ST_TERM;
                    else if (a_term)       state_d = ST_DRAIN_B;
                    else if (b_term)       state_d = ST_DRAIN_A;
                    else if (a_wins)       a_deq   = fire;
                    else                   b_deq   = fire;
                end
            end
            ST_DRAIN_A: begin
                // B's terminator waits at its head until A's arrives.
                if (!i_a_empty) begin
                    if (a_term) state_d = ST_TERM;
                    else        a_deq   = fire;
                end
            end
            ST_DRAIN_B: begin
                if (!i_b_empty) begin
                    if (b_term) state_d = ST_TERM;
                    else        b_deq   = fire;
                end
            end
            ST_TERM: begin
                // Both terminators leave together; only A's is forwarded.
                if (fire && !i_a_empty && !i_b_empty) begin
                    a_deq   = 1'b1;
                    b_deq   = 1'b1;
                    state_d = ST_MERGE;
                end
            end
            default: state_d = ST_MERGE;
        endcase
    end

    // Output register and counters. A double pop only happens in TERM.
    always_comb begin
        out_enq_d    = a_deq | b_deq;
        out_data_d   = out_data_q;
        rec_cnt_d    = rec_cnt_q;
        stream_cnt_d = stream_cnt_q;

        if (a_deq)      out_data_d = i_a_data;
        else if (b_deq) out_data_d = i_b_data;

        if (a_deq && b_deq) begin
            stream_cnt_d = stream_cnt_q + 8'd1;
            rec_cnt_d    = '0;
        end else if ((a_deq || b_deq) && (rec_cnt_q != '1)) begin
            rec_cnt_d = rec_cnt_q + P_CNTW'(1);
        end
    end

    // NOTE: the data register is reset along with the control state so that
    // o_out_data reads 0 after reset rather than a stale record.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= ST_MERGE;
            out_data_q   <= '0;
            out_enq_q    <= 1'b0;
            rec_cnt_q    <= '0;
            stream_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q      <= state_d;
            out_data_q   <= out_data_d;
            out_enq_q    <= out_enq_d;
            rec_cnt_q    <= rec_cnt_d;
            stream_cnt_q <= stream_cnt_d;
        end
    end

    // Pops are suppressed for the whole time reset is held.
    assign o_a_deq      = a_deq & ~i_rst;
    assign o_b_deq      = b_deq & ~i_rst;
    assign o_out_data   = out_data_q;
    assign o_out_enq    = out_enq_q;
    assign o_state      = state_q;
    assign o_rec_cnt    = rec_cnt_q;
    assign o_stream_cnt = stream_cnt_q;

endmodule

// File: tb/tb_merge_pair_ctrl.sv
// -----------------------------------------------------------------------------
// tb_merge_pair_ctrl
//   Input FIFOs are modelled as queues. Each stream pair pushed into them also
//   pushes its expected output (a stable descending merge plus one terminator)
//   into a scoreboard; a monitor pops and compares on every o_out_enq.
// -----------------------------------------------------------------------------

module tb_merge_pair_ctrl;
    import merge_pair_ctrl_pkg::*;

    localparam int W  = 128;
    localparam int KW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a_data, b_data, out_data;
    logic          a_empty, b_empty, a_deq, b_deq;
    logic          out_full, out_enq;
    logic [1:0]    state;
    logic [CW-1:0] rec_cnt;
    logic [7:0]    stream_cnt;

    merge_pair_ctrl #(
        .P_WIDTH (W),
        .P_KEYW  (KW),
        .P_CNTW  (CW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_a_data     (a_data),
        .i_a_empty    (a_empty),
        .o_a_deq      (a_deq),
        .i_b_data     (b_data),
        .i_b_empty    (b_empty),
        .o_b_deq      (b_deq),
        .i_out_full   (out_full),
        .o_out_data   (out_data),
        .o_out_enq    (out_enq),
        .o_state      (state),
        .o_rec_cnt    (rec_cnt),
        .o_stream_cnt (stream_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  data;
        logic [CW-1:0] cnt;
        logic [7:0]    strm;
    } exp_t;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int           sa[$];
    int           sb[$];
    exp_t         exp_q[$];

    int n_checks     = 0;
    int n_pass       = 0;
    int pairs_issued = 0;
    bit noise        = 1'b0;
    bit a_hide       = 1'b0;
    bit b_hide       = 1'b0;
    int full_hold    = 0;
    int b_hide_hold  = 0;

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    endtask

    function automatic logic [W-1:0] mk_rec(input int key);
        logic [KW-1:0] k;
        k = key[KW-1:0];
        return {k, $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic void drive_inputs();
        a_empty = (qa.size() == 0) || a_hide;
        b_empty = (qb.size() == 0) || b_hide;
        a_data  = (qa.size() != 0) ? qa[0] : '0;
        b_data  = (qb.size() != 0) ? qb[0] : '0;
    endfunction

    // Turns the key lists in sa/sb into records, queues them behind each FIFO
    // and records the expected output: a stable descending merge (A first on
    // equal keys) followed by A's terminator.
    task automatic add_pair();
        logic [W-1:0] ra[$];
        logic [W-1:0] rb[$];
        logic [W-1:0] ta, tb;
        int           i, j;
        exp_t         e;
        foreach (sa[k]) ra.push_back(mk_rec(sa[k]));
        foreach (sb[k]) rb.push_back(mk_rec(sb[k]));
        ta = mk_rec(0);
        tb = mk_rec(0);
        i  = 0;
        j  = 0;
        while (i < ra.size() || j < rb.size()) begin
            if (j >= rb.size() || (i < ra.size() && ra[i][W-1 -: KW] >= rb[j][W-1 -: KW])) begin
                e.data = ra[i];
                i++;
            end else begin
                e.data = rb[j];
                j++;
            end
            e.cnt  = CW'(i + j);
            e.strm = 8'(pairs_issued % 256);
            exp_q.push_back(e);
        end
        pairs_issued++;
        e.data = ta;
        e.cnt  = '0;
        e.strm = 8'(pairs_issued % 256);
        exp_q.push_back(e);
        foreach (ra[k]) qa.push_back(ra[k]);
        foreach (rb[k]) qb.push_back(rb[k]);
        qa.push_back(ta);
        qb.push_back(tb);
        sa.delete();
        sb.delete();
    endtask

    task automatic fill_rand(input bit to_a);
        int n, k;
        n = $urandom_range(0, 6);
        k = $urandom_range(40, 10);
        repeat (n) begin
            if (to_a) sa.push_back(k);
            else      sb.push_back(k);
            k -= $urandom_range(0, 3);
            if (k < 1) k = 1;
        end
    endtask

    // Moves the caller just past the driver's post-edge update.
    task automatic sync();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int budget);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || qa.size() != 0 || qb.size() != 0) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("drain_in_budget", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // FIFO driver plus per-cycle protocol rules.
    initial begin : driver
        bit           da, db;
        logic [W-1:0] tmp;
        forever begin
            @(negedge clk);
            da = a_deq;
            db = b_deq;
            if (!rst) begin
                check("a_deq_while_empty", a_deq & a_empty, 0);
                check("b_deq_while_empty", b_deq & b_empty, 0);
                if (out_full) check("deq_while_full", a_deq | b_deq, 0);
                if (state == ST_MERGE && (a_empty || b_empty))
                    check("merge_needs_both", a_deq | b_deq, 0);
                if (a_deq && a_data[W-1 -: KW] == 0) check("a_term_alone", b_deq, 1);
                if (b_deq && b_data[W-1 -: KW] == 0) check("b_term_alone", a_deq, 1);
            end
            @(posedge clk);
            #1;
            if (da && qa.size() > 0) tmp = qa.pop_front();
            if (db && qb.size() > 0) tmp = qb.pop_front();
            if (full_hold > 0) begin
                out_full = 1'b1;
                full_hold--;
            end else begin
                out_full = noise && ($urandom_range(0, 3) == 0);
            end
            a_hide = noise && ($urandom_range(0, 4) == 0);
            if (b_hide_hold > 0) begin
                b_hide = 1'b1;
                b_hide_hold--;
            end else begin
                b_hide = noise && ($urandom_range(0, 4) == 0);
            end
            drive_inputs();
        end
    end

    // Scoreboard monitor.
    initial begin : monitor
        bit   prev_deq;
        exp_t e;
        prev_deq = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_deq = 1'b0;
            end else begin
                check("enq_follows_deq", out_enq, prev_deq);
                if (out_enq) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_enq", out_enq, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_data", out_data, e.data);
                        check("rec_cnt", rec_cnt, e.cnt);
                        check("stream_cnt", stream_cnt, e.strm);
                    end
                end
                prev_deq = a_deq | b_deq;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst      = 1'b0;
        out_full = 1'b0;
        drive_inputs();
        #1 rst = 1'b1;
        #1;
        check("rst_state", state, ST_MERGE);
        check("rst_enq", out_enq, 0);
        check("rst_data", out_data, 0);
        check("rst_rec_cnt", rec_cnt, 0);
        check("rst_stream_cnt", stream_cnt, 0);
        check("rst_deq", a_deq | b_deq, 0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;

        // Interleave with a tie.
        sync();
        sa = '{9, 5, 2};
        sb = '{8, 5, 1};
        add_pair();
        drive_inputs();
        wait_done(100);

        // Backpressure mid-stream.
        sync();
        sa = '{30, 28, 26, 24, 22, 20};
        sb = '{29, 27, 25, 23, 21};
        add_pair();
        drive_inputs();
        repeat (3) @(posedge clk);
        #2 full_hold = 5;
        wait_done(200);

        // B empty for three cycles while in MERGE.
        sync();
        b_hide      = 1'b1;
        b_hide_hold = 3;
        sa = '{12, 11, 10};
        sb = '{11, 3};
        add_pair();
        drive_inputs();
        wait_done(200);

        // Uneven streams: A is only a terminator.
        sync();
        sb = '{7, 6, 3};
        add_pair();
        drive_inputs();
        wait_done(100);

        // Back-to-back stream pairs.
        sync();
        sa = '{5, 4};
        sb = '{6};
        add_pair();
        sa = '{2};
        sb = '{3, 3};
        add_pair();
        drive_inputs();
        wait_done(200);

        // Random streams with random full and empty gaps.
        noise = 1'b1;
        for (int p = 0; p < 40; p++) begin
            sync();
            fill_rand(1'b1);
            fill_rand(1'b0);
            add_pair();
            drive_inputs();
        end
        wait_done(5000);
        noise = 1'b0;

        // Terminator-only pairs until the stream counter wraps past 255.
        sync();
        while (pairs_issued < 258) add_pair();
        drive_inputs();
        wait_done(5000);

        // Asynchronous reset in the middle of DRAIN_A.
        sync();
        sa = '{30, 29, 28, 27, 26, 25, 24, 23, 22, 21};
        add_pair();
        drive_inputs();
        for (int c = 0; c < 50 && state != ST_DRAIN_A; c++) @(negedge clk);
        check("reach_drain_a", state, ST_DRAIN_A);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_state", state, ST_MERGE);
        check("mid_rst_enq", out_enq, 0);
        check("mid_rst_data", out_data, 0);
        check("mid_rst_rec_cnt", rec_cnt, 0);
        check("mid_rst_stream_cnt", stream_cnt, 0);
        check("mid_rst_deq", a_deq | b_deq, 0);
        qa.delete();
        qb.delete();
        exp_q.delete();
        pairs_issued = 0;
        drive_inputs();
        @(negedge clk);
        check("rst_held_deq", a_deq | b_deq, 0);
        #2 rst = 1'b0;

        // Normal operation after reset.
        sync();
        sa = '{4};
        sb = '{4, 2};
        add_pair();
        drive_inputs();
        wait_done(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
